mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit directly downstream of the EX/MEM pipeline register. It consumes that register's ALUResult, WriteData, Rd and control outputs, plus the load/store size. It drives a word-wide request/ready data-memory bus with byte strobes and returns aligned, extended load data to the MEM/WB register. While the memory inserts wait states it asserts a pipeline stall, and it bounds each access with a timeout.

Parameters:
TIMEOUT, 16, maximum WAIT cycles before an access is aborted with a fault. Legal range 1..255.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
ALUResult_in  in  32  effective byte address from EX/MEM
WriteData_in  in  32  store data from EX/MEM
Funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ResultSrc_in  in  2  01 = load; other values = no load
MemWrite_in  in  1  store request
RegWrite_in  in  1  from EX/MEM
Rd_in  in  5  from EX/MEM
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  32  word address {ALUResult_in[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables; 0000 on reads
mem_ready  in  1  access complete this cycle
mem_rdata  in  32  read word, valid when mem_ready=1
Stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (drives their en low)
ReadData_out  out  32  extended load result to MEM/WB
RegWrite_out  out  1  RegWrite_in gated by fault
MemFault  out  1  one-cycle pulse: misaligned or timeout
FaultAddr  out  32  address of last faulting access, held

Behaviour:
- Reset (rst=0, async): state IDLE, wait counter 0, rdata_q 0, FaultAddr 0. mem_req=0, Stall=0, MemFault=0, ReadData_out=0, RegWrite_out=0.
- load = (ResultSrc_in==2'b01). access = load | MemWrite_in. If both load and MemWrite_in are set, the store wins (mem_we=1) and no load data is returned.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00. A misaligned access issues no bus request. It produces MemFault=1 for one cycle, FaultAddr<=ALUResult_in, RegWrite_out=0 and Stall=0, and the state stays IDLE.
- Stores: SB replicates byte [7:0] to all lanes, with strobe = 0001 shifted left by addr[1:0]. SH replicates the halfword, with strobe 0011 or 1100. SW uses strobe 1111.
- Loads: select the byte or halfword at addr[1:0] from the word. Sign-extend for B/H and zero-extend for BU/HU. Funct3 values other than 000, 001, 010, 100, 101 are treated as W.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - mem_req = valid access (combinational).
  - If mem_ready=1 in the same cycle (zero-wait): no stall. ReadData_out is formatted from mem_rdata combinationally. Stay IDLE.
  - If mem_ready=0: Stall=1, counter<=1, go to WAIT.
- WAIT:
  - mem_req=1 and Stall=1. Address, data and strobes are stable because the upstream pipeline is frozen.
  - mem_ready=1: rdata_q<=formatted mem_rdata, go to RESP.
  - Else if counter==TIMEOUT: abort, fault_q<=1, FaultAddr<=address, go to RESP.
  - Else counter<=counter+1.
- RESP:
  - mem_req=0, Stall=0.
  - ReadData_out=rdata_q, or 0 on fault. MemFault=fault_q. RegWrite_out=RegWrite_in & ~fault_q.
  - Next state IDLE; fault_q and counter clear.
- Stall count per access: 0 for zero-wait. Otherwise k+1, where k is the number of WAIT cycles before ready or abort.
- No access in IDLE: mem_req=0, ReadData_out=0, RegWrite_out=RegWrite_in.
- mem_ready while mem_req=0 is ignored.
- rst asserted mid-WAIT: the FSM returns to IDLE immediately and mem_req drops asynchronously. The access is abandoned with no fault.

Test Plan:
1. Zero-wait SW: addr 0x0000_1004, data 0xDEADBEEF, mem_ready=1 in the request cycle -> mem_req=1, mem_addr=0x1004, wstrb=1111, Stall never 1.
2. LB with 2 wait states: addr 0x2003, mem_rdata=0x80FF_FF7F, ready on the 3rd request cycle -> Stall high for 3 cycles. In RESP, ReadData_out=0xFFFF_FF80, RegWrite_out=1.
3. SH at addr 0x0102, data 0x0000_ABCD -> mem_wdata=0xABCD_ABCD, wstrb=1100. LHU at the same address with rdata 0xABCD_0000 -> ReadData_out=0x0000_ABCD.
4. Misaligned LW at 0x0006 -> mem_req stays 0, MemFault pulses 1 cycle, FaultAddr=0x0000_0006, RegWrite_out=0, Stall=0.
5. Timeout with TIMEOUT=4, load, mem_ready held 0 -> Stall high 5 cycles. In RESP, MemFault=1, ReadData_out=0, RegWrite_out=0, then back to IDLE.
6. rst driven low in the 2nd WAIT cycle -> mem_req and Stall go to 0 immediately with no clock edge. After release, state is IDLE and MemFault=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a request/ready word bus, formats load data,
// stalls the pipeline on wait states and aborts accesses that exceed TIMEOUT cycles.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUResult_in,
   input  logic [31:0] WriteData_in,
   input  logic [2:0]  Funct3_in,
   input  logic [1:0]  ResultSrc_in,
   input  logic        MemWrite_in,
   input  logic        RegWrite_in,
   input  logic [4:0]  Rd_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        Stall,
   output logic [31:0] ReadData_out,
   output logic        RegWrite_out,
   output logic        MemFault,
   output logic [31:0] FaultAddr
);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] fault_addr_q, fault_addr_d;
   logic        fault_q, fault_d;

   logic        is_load, is_store, access, is_byte, is_half, is_word;
   logic        misaligned, valid, want_data;
   logic [31:0] lane, load_fmt;
   logic        req, stall, fault_pulse, rw_out;
   logic [31:0] rd_out;
   logic        unused_rd;

   assign unused_rd = ^Rd_in;

   assign is_load    = (ResultSrc_in == 2'b01);
   assign is_store   = MemWrite_in;
   assign access     = is_load | is_store;
   assign want_data  = is_load & ~is_store;
   assign is_byte    = (Funct3_in == 3'b000) || (Funct3_in == 3'b100);
   assign is_half    = (Funct3_in == 3'b001) || (Funct3_in == 3'b101);
   assign is_word    = ~is_byte & ~is_half;
   assign misaligned = access & ((is_half & ALUResult_in[0]) | (is_word & (|ALUResult_in[1:0])));
   assign valid      = access & ~misaligned;

   assign mem_we   = is_store;
   assign mem_addr = {ALUResult_in[31:2], 2'b00};

   always_comb begin
      mem_wdata = WriteData_in;
      mem_wstrb = 4'b0000;
      if (is_store) begin
         if (is_byte) begin
            mem_wdata = {4{WriteData_in[7:0]}};
            mem_wstrb = 4'b0001 << ALUResult_in[1:0];
         end else if (is_half) begin
            mem_wdata = {2{WriteData_in[15:0]}};
            mem_wstrb = ALUResult_in[1] ? 4'b1100 : 4'b0011;
         end else begin
            mem_wstrb = 4'b1111;
         end
      end
   end

   // Aligned accesses only, so a byte-granular shift also serves halfwords.
   assign lane = mem_rdata >> {ALUResult_in[1:0], 3'b000};

   always_comb begin
      case (Funct3_in)
         3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
         3'b100:  load_fmt = {24'b0, lane[7:0]};
         3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
         3'b101:  load_fmt = {16'b0, lane[15:0]};
         default: load_fmt = mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      req          = 1'b0;
      stall        = 1'b0;
      fault_pulse  = 1'b0;
      rd_out       = 32'b0;
      rw_out       = RegWrite_in;
      unique case (state_q)
         StIdle: begin
            if (misaligned) begin
               fault_pulse  = 1'b1;
               fault_addr_d = ALUResult_in;
               rw_out       = 1'b0;
            end else if (valid) begin
               req = 1'b1;
               if (mem_ready) begin
                  if (want_data) rd_out = load_fmt;
               end else begin
                  stall   = 1'b1;
                  rw_out  = 1'b0;
                  cnt_d   = 8'd1;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            req    = 1'b1;
            stall  = 1'b1;
            rw_out = 1'b0;
            if (mem_ready) begin
               rdata_d = want_data ? load_fmt : 32'b0;
               state_d = StResp;
            end else if (cnt_q == TimeoutCnt) begin
               fault_d      = 1'b1;
               fault_addr_d = ALUResult_in;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StResp: begin
            rd_out      = fault_q ? 32'b0 : rdata_q;
            fault_pulse = fault_q;
            rw_out      = RegWrite_in & ~fault_q;
            fault_d     = 1'b0;
            cnt_d       = 8'd0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Reset must silence the bus and pipeline controls without waiting for a clock.
   assign mem_req      = rst & req;
   assign Stall        = rst & stall;
   assign MemFault     = rst & fault_pulse;
   assign ReadData_out = rst ? rd_out : 32'b0;
   assign RegWrite_out = rst & rw_out;
   assign FaultAddr    = fault_addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         cnt_q        <= 8'd0;
         rdata_q      <= 32'b0;
         fault_q      <= 1'b0;
         fault_addr_q <= 32'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus queues expected responses, a negedge
// monitor pops and compares them whenever an access completes.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResult_in, WriteData_in, mem_rdata;
   logic [2:0]  Funct3_in;
   logic [1:0]  ResultSrc_in;
   logic        MemWrite_in, RegWrite_in, mem_ready;
   logic [4:0]  Rd_in;
   logic        mem_req, mem_we, Stall, RegWrite_out, MemFault;
   logic [31:0] mem_addr, mem_wdata, ReadData_out, FaultAddr;
   logic [3:0]  mem_wstrb;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .ALUResult_in (ALUResult_in),
      .WriteData_in (WriteData_in),
      .Funct3_in    (Funct3_in),
      .ResultSrc_in (ResultSrc_in),
      .MemWrite_in  (MemWrite_in),
      .RegWrite_in  (RegWrite_in),
      .Rd_in        (Rd_in),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .Stall        (Stall),
      .ReadData_out (ReadData_out),
      .RegWrite_out (RegWrite_out),
      .MemFault     (MemFault),
      .FaultAddr    (FaultAddr)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        rw;
      logic        fault;
      int          stalls;
   } resp_t;

   resp_t exp_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic go_idle();
      ALUResult_in = 32'h0;
      WriteData_in = 32'h0;
      Funct3_in    = 3'b000;
      ResultSrc_in = 2'b00;
      MemWrite_in  = 1'b0;
      RegWrite_in  = 1'b0;
      Rd_in        = 5'd0;
      mem_ready    = 1'b0;
      mem_rdata    = 32'h0;
   endtask

   // wait_n: WAIT cycle index at which ready rises (0 = zero-wait, -1 = never).
   task automatic access(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [1:0] rs, input logic mw,
                         input logic rw, input logic [31:0] rdata, input int wait_n,
                         input logic [31:0] e_rd, input logic e_rw, input logic e_fault,
                         input int e_stalls, input logic e_req, input logic [31:0] e_wdata,
                         input logic [3:0] e_wstrb);
      resp_t r;
      int    c;
      r.rdata  = e_rd;
      r.rw     = e_rw;
      r.fault  = e_fault;
      r.stalls = e_stalls;
      exp_q.push_back(r);
      @(posedge clk); #1;
      ALUResult_in = addr;
      WriteData_in = wdata;
      Funct3_in    = f3;
      ResultSrc_in = rs;
      MemWrite_in  = mw;
      RegWrite_in  = rw;
      Rd_in        = 5'd5;
      mem_rdata    = rdata;
      mem_ready    = (wait_n == 0);
      c = 0;
      @(negedge clk);
      check("mem_req", mem_req, e_req);
      if (e_req) begin
         check("mem_addr", mem_addr, {addr[31:2], 2'b00});
         check("mem_we", mem_we, mw);
         check("mem_wstrb", mem_wstrb, e_wstrb);
         if (mw) check("mem_wdata", mem_wdata, e_wdata);
      end
      while (Stall && c < 40) begin
         @(posedge clk); #1;
         c++;
         mem_ready = (c == wait_n);
         @(negedge clk);
      end
      if (Stall) check("stall_bound", Stall, 1'b0);
      @(posedge clk); #1;
      go_idle();
   endtask

   // Monitor: a response is a non-stalled cycle that ends an access.
   initial begin
      int    stalls;
      logic  prev;
      resp_t r;
      stalls = 0;
      prev   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stalls = 0;
            prev   = 1'b0;
         end else if (Stall) begin
            stalls++;
            prev = 1'b1;
         end else begin
            if (MemFault || (mem_req && mem_ready) || prev) begin
               check("resp_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  r = exp_q.pop_front();
                  check("resp_rdata", ReadData_out, r.rdata);
                  check("resp_regwrite", RegWrite_out, r.rw);
                  check("resp_fault", MemFault, r.fault);
                  check("resp_stalls", stalls, r.stalls);
               end
            end
            stalls = 0;
            prev   = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      go_idle();
      RegWrite_in = 1'b1;
      #2;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_stall", Stall, 1'b0);
      check("rst_memfault", MemFault, 1'b0);
      check("rst_readdata", ReadData_out, 32'h0);
      check("rst_regwrite", RegWrite_out, 1'b0);
      check("rst_faultaddr", FaultAddr, 32'h0);
      #10;
      rst = 1'b1;
      @(negedge clk);
      check("idle_regwrite_pass", RegWrite_out, 1'b1);
      check("idle_mem_req", mem_req, 1'b0);
      go_idle();

      // addr, wdata, f3, rs, mw, rw, rdata, wait | e_rd, e_rw, e_fault, e_stalls, e_req, e_wdata, e_wstrb
      access(32'h1004, 32'hDEADBEEF, 3'b010, 2'b00, 1'b1, 1'b0, 32'h0, 0,
             32'h0, 1'b0, 1'b0, 0, 1'b1, 32'hDEADBEEF, 4'b1111);
      access(32'h2003, 32'h0, 3'b000, 2'b01, 1'b0, 1'b1, 32'h80FFFF7F, 2,
             32'hFFFFFF80, 1'b1, 1'b0, 3, 1'b1, 32'h0, 4'b0000);
      access(32'h0102, 32'h0000ABCD, 3'b001, 2'b00, 1'b1, 1'b0, 32'h0, 1,
             32'h0, 1'b0, 1'b0, 2, 1'b1, 32'hABCDABCD, 4'b1100);
      access(32'h0102, 32'h0, 3'b101, 2'b01, 1'b0, 1'b1, 32'hABCD0000, 0,
             32'h0000ABCD, 1'b1, 1'b0, 0, 1'b1, 32'h0, 4'b0000);

      // Misaligned LW with a stray ready that must be ignored.
      access(32'h0006, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 32'h0, 0,
             32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h0, 4'b0000);
      @(negedge clk);
      check("mis_pulse_end", MemFault, 1'b0);
      check("mis_faultaddr", FaultAddr, 32'h0000_0006);

      access(32'h3000, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 32'h11111111, -1,
             32'h0, 1'b0, 1'b1, 5, 1'b1, 32'h0, 4'b0000);
      @(negedge clk);
      check("to_pulse_end", MemFault, 1'b0);
      check("to_faultaddr", FaultAddr, 32'h0000_3000);
      check("to_back_idle", Stall, 1'b0);

      // Ready on the last allowed WAIT cycle wins over the timeout.
      access(32'h2002, 32'h0, 3'b001, 2'b01, 1'b0, 1'b1, 32'h80011234, 4,
             32'hFFFF8001, 1'b1, 1'b0, 5, 1'b1, 32'h0, 4'b0000);
      access(32'h0001, 32'h12345678, 3'b000, 2'b00, 1'b1, 1'b1, 32'h0, 0,
             32'h0, 1'b1, 1'b0, 0, 1'b1, 32'h78787878, 4'b0010);
      access(32'h0002, 32'h0, 3'b100, 2'b01, 1'b0, 1'b1, 32'h00AB0000, 1,
             32'h000000AB, 1'b1, 1'b0, 2, 1'b1, 32'h0, 4'b0000);
      access(32'h0010, 32'h0, 3'b011, 2'b01, 1'b0, 1'b1, 32'h89ABCDEF, 0,
             32'h89ABCDEF, 1'b1, 1'b0, 0, 1'b1, 32'h0, 4'b0000);
      access(32'h0040, 32'h00000055, 3'b010, 2'b01, 1'b1, 1'b1, 32'h12345678, 0,
             32'h0, 1'b1, 1'b0, 0, 1'b1, 32'h00000055, 4'b1111);
      access(32'h0005, 32'h0000FFFF, 3'b001, 2'b00, 1'b1, 1'b1, 32'h0, 1,
             32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h0, 4'b0000);
      @(negedge clk);
      check("sh_mis_faultaddr", FaultAddr, 32'h0000_0005);

      // Reset asserted in the second WAIT cycle.
      @(posedge clk); #1;
      ALUResult_in = 32'h0500;
      Funct3_in    = 3'b010;
      ResultSrc_in = 2'b01;
      RegWrite_in  = 1'b1;
      mem_ready    = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      check("wait2_req", mem_req, 1'b1);
      rst = 1'b0;
      #1;
      check("async_req_drop", mem_req, 1'b0);
      check("async_stall_drop", Stall, 1'b0);
      go_idle();
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_fault", MemFault, 1'b0);
      check("post_rst_stall", Stall, 1'b0);
      check("post_rst_faultaddr", FaultAddr, 32'h0);

      access(32'h0020, 32'h0, 3'b010, 2'b01, 1'b0, 1'b1, 32'hCAFEF00D, 0,
             32'hCAFEF00D, 1'b1, 1'b0, 0, 1'b1, 32'h0, 4'b0000);

      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
